motoro3_ramp_ctrl: RTL and testbench

- Command/speed-ramp stage directly upstream of the 3-phase motor core; its outputs drive that core's m3start, m3invOrStop and m3freq inputs.
- Accepts target frequency/direction commands over a valid/ready handshake.
- Slews m3freq by ±1 per ramp tick, never steps it abruptly.
- Inserts decelerate-flip-accelerate on direction change and a timed brake phase on stop.

---
 rtl/motoro3_ramp_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_motoro3_ramp_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_ramp_ctrl.sv
// Command/speed-ramp stage feeding the 3-phase motor core (m3start/m3invOrStop/m3freq).
// Define MOTORO3_RAMP_ESTOP_EN to add the eStop input and sticky fault output.
module motoro3_ramp_ctrl #(
  parameter int RAMP_DIV  = 10000,
  parameter int MIN_FREQ  = 1,
  parameter int MAX_FREQ  = 1000,
  parameter int BRAKE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [9:0] cmdFreq,
  input  logic       cmdDir,
  output logic       m3start,
  output logic       m3invOrStop,
  output logic [9:0] m3freq,
  output logic       atSpeed,
  output logic       busy
`ifdef MOTORO3_RAMP_ESTOP_EN
  ,
  input  logic       eStop,
  output logic       fault
`endif
);

  localparam logic [9:0]  MIN_F      = 10'(MIN_FREQ);
  localparam logic [9:0]  MAX_F      = 10'(MAX_FREQ);
  localparam logic [23:0] DIV_LAST   = 24'(RAMP_DIV - 1);
  localparam logic [23:0] BRAKE_LAST = 24'(BRAKE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_RUN   = 2'd2,
    S_BRAKE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  tgt_freq_q, tgt_freq_d;
  logic        tgt_dir_q, tgt_dir_d;
  logic        cur_dir_q, cur_dir_d;
  logic [23:0] presc_q, presc_d;
  logic [23:0] brake_cnt_q, brake_cnt_d;
  logic        m3start_q, m3start_d;
  logic        m3inv_q, m3inv_d;
  logic [9:0]  m3freq_q, m3freq_d;
  logic        at_speed_q, at_speed_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        fault_q, fault_d;

  logic        estop_w;
  logic        cmd_fire;
  logic [9:0]  cmd_freq_clamped;
  logic        cmd_differs;
  logic        tick;
  logic        stop_pend;
  logic        dir_mis;
  logic        at_tgt;

`ifdef MOTORO3_RAMP_ESTOP_EN
  assign estop_w = eStop;
  assign fault   = fault_q;
`else
  assign estop_w = 1'b0;
`endif

  // A zero command means stop; any nonzero command lands in MIN_F..MAX_F.
  always_comb begin
    cmd_freq_clamped = cmdFreq;
    if (cmdFreq == 10'd0) begin
      cmd_freq_clamped = 10'd0;
    end else if (cmdFreq > MAX_F) begin
      cmd_freq_clamped = MAX_F;
    end else if (cmdFreq < MIN_F) begin
      cmd_freq_clamped = MIN_F;
    end
  end

  assign cmd_fire    = cmdValid & cmd_ready_q;
  assign cmd_differs = (cmd_freq_clamped != tgt_freq_q) || (cmdDir != tgt_dir_q);
  assign tick        = (state_q == S_RAMP) && (presc_q == DIV_LAST);
  assign stop_pend   = (tgt_freq_q == 10'd0);
  assign dir_mis     = (tgt_dir_q != cur_dir_q);
  assign at_tgt      = !stop_pend && !dir_mis && (m3freq_q == tgt_freq_q);

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tgt_freq_q  <= 10'd0;
      tgt_dir_q   <= 1'b0;
      cur_dir_q   <= 1'b0;
      presc_q     <= 24'd0;
      brake_cnt_q <= 24'd0;
      m3start_q   <= 1'b0;
      m3inv_q     <= 1'b0;
      m3freq_q    <= 10'd0;
      at_speed_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_freq_q  <= tgt_freq_d;
      tgt_dir_q   <= tgt_dir_d;
      cur_dir_q   <= cur_dir_d;
      presc_q     <= presc_d;
      brake_cnt_q <= brake_cnt_d;
      m3start_q   <= m3start_d;
      m3inv_q     <= m3inv_d;
      m3freq_q    <= m3freq_d;
      at_speed_q  <= at_speed_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next state. RUN is entered as soon as the target is reached, but never on an
  // edge that also accepts a new command, so atSpeed always refers to the latched target.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire && (cmd_freq_clamped != 10'd0)) begin
          state_d = S_RAMP;
        end
      end
      S_RAMP: begin
        if (tick && stop_pend && (m3freq_q == MIN_F)) begin
          state_d = S_BRAKE;
        end else if (at_tgt && !cmd_fire) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cmd_fire && cmd_differs) begin
          state_d = S_RAMP;
        end
      end
      S_BRAKE: begin
        if (brake_cnt_q == BRAKE_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (estop_w && ((state_q == S_RAMP) || (state_q == S_RUN))) begin
      state_d = S_BRAKE;
    end
  end

  // Datapath and output next values.
  always_comb begin
    tgt_freq_d  = tgt_freq_q;
    tgt_dir_d   = tgt_dir_q;
    cur_dir_d   = cur_dir_q;
    presc_d     = presc_q;
    brake_cnt_d = brake_cnt_q;
    m3start_d   = m3start_q;
    m3inv_d     = m3inv_q;
    m3freq_d    = m3freq_q;

    if (cmd_fire && !((state_q == S_IDLE) && (cmd_freq_clamped == 10'd0))) begin
      tgt_freq_d = cmd_freq_clamped;
      tgt_dir_d  = cmdDir;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_fire && (cmd_freq_clamped != 10'd0)) begin
          cur_dir_d = cmdDir;
          m3freq_d  = MIN_F;
          m3start_d = 1'b1;
          m3inv_d   = cmdDir;
          presc_d   = 24'd0;
        end
      end
      S_RAMP: begin
        presc_d = tick ? 24'd0 : presc_q + 24'd1;
        // Ramp rules use the target latched before this edge.
        if (tick) begin
          if ((stop_pend || dir_mis) && (m3freq_q > MIN_F)) begin
            m3freq_d = m3freq_q - 10'd1;
          end else if (!stop_pend) begin
            if (dir_mis) begin
              cur_dir_d = ~cur_dir_q;
              m3inv_d   = ~cur_dir_q;
            end else if (m3freq_q < tgt_freq_q) begin
              m3freq_d = m3freq_q + 10'd1;
            end else if (m3freq_q > tgt_freq_q) begin
              m3freq_d = m3freq_q - 10'd1;
            end
          end
        end
      end
      S_RUN: begin
        if (cmd_fire && cmd_differs) begin
          presc_d = 24'd0;
        end
      end
      S_BRAKE: begin
        brake_cnt_d = brake_cnt_q + 24'd1;
      end
      default: ;
    endcase

    if ((state_d == S_BRAKE) && (state_q != S_BRAKE)) begin
      m3start_d   = 1'b1;
      m3inv_d     = 1'b1;
      m3freq_d    = 10'd0;
      brake_cnt_d = 24'd0;
    end

    if ((state_d == S_IDLE) && (state_q == S_BRAKE)) begin
      m3start_d  = 1'b0;
      m3inv_d    = 1'b0;
      m3freq_d   = 10'd0;
      tgt_freq_d = 10'd0;
      tgt_dir_d  = 1'b0;
      cur_dir_d  = 1'b0;
    end

    fault_d     = fault_q | estop_w;
    at_speed_d  = (state_d == S_RUN) && (m3freq_d == tgt_freq_d);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d != S_BRAKE) && !fault_d;
  end

  assign cmdReady    = cmd_ready_q;
  assign m3start     = m3start_q;
  assign m3invOrStop = m3inv_q;
  assign m3freq      = m3freq_q;
  assign atSpeed     = at_speed_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Self-checking bench for motoro3_ramp_ctrl: directed scenarios plus random commands,
// every cycle compared against a mode/timer-level reference model.
module tb_motoro3_ramp_ctrl;

  localparam int RAMP_DIV  = 4;
  localparam int MINF      = 1;
  localparam int MAXF      = 1000;
  localparam int BRAKE_CYC = 8;

  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_RUN   = 2;
  localparam int M_BRAKE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_freq = 10'd0;
  logic       cmd_dir = 1'b0;
  logic       cmd_ready;
  logic       m3start;
  logic       m3inv;
  logic [9:0] m3freq;
  logic       atspeed;
  logic       busy;
`ifdef MOTORO3_RAMP_ESTOP_EN
  logic       e_stop = 1'b0;
  logic       fault;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int md_mode = M_IDLE;
  int md_freq = 0;
  int md_tgt = 0;
  int md_wait = RAMP_DIV;
  int md_brake = 0;
  bit md_tdir = 1'b0;
  bit md_cur = 1'b0;
  bit md_fault = 1'b0;

  bit rec_on = 1'b0;
  int last_pair = 0;
  int seq[$];

  motoro3_ramp_ctrl #(
    .RAMP_DIV (RAMP_DIV),
    .MIN_FREQ (MINF),
    .MAX_FREQ (MAXF),
    .BRAKE_CYC(BRAKE_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmdValid   (cmd_valid),
    .cmdReady   (cmd_ready),
    .cmdFreq    (cmd_freq),
    .cmdDir     (cmd_dir),
    .m3start    (m3start),
    .m3invOrStop(m3inv),
    .m3freq     (m3freq),
    .atSpeed    (atspeed),
    .busy       (busy)
`ifdef MOTORO3_RAMP_ESTOP_EN
    ,
    .eStop      (e_stop),
    .fault      (fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampf(input int f);
    if (f == 0) return 0;
    if (f > MAXF) return MAXF;
    if (f < MINF) return MINF;
    return f;
  endfunction

  task automatic enter_brake();
    md_mode  = M_BRAKE;
    md_freq  = 0;
    md_brake = BRAKE_CYC;
  endtask

  // One rising edge of the reference model, using the inputs held across that edge.
  task automatic model_edge();
    int  prev_mode;
    int  c;
    bit  fire;
    bit  es;
    bit  stopping;
    bit  reversing;
    bit  settled;
    if (rst) begin
      md_mode = M_IDLE; md_freq = 0; md_tgt = 0; md_tdir = 0; md_cur = 0;
      md_wait = RAMP_DIV; md_brake = 0; md_fault = 0;
      return;
    end
`ifdef MOTORO3_RAMP_ESTOP_EN
    es = e_stop;
`else
    es = 1'b0;
`endif
    prev_mode = md_mode;
    fire = cmd_valid && (md_mode != M_BRAKE) && !md_fault;
    c = clampf(int'(cmd_freq));
    case (md_mode)
      M_IDLE: begin
        if (fire && c != 0) begin
          md_tgt = c; md_tdir = cmd_dir; md_cur = cmd_dir;
          md_freq = MINF; md_wait = RAMP_DIV; md_mode = M_RAMP;
        end
      end
      M_RAMP: begin
        stopping  = (md_tgt == 0);
        reversing = (md_tdir != md_cur);
        settled   = !stopping && !reversing && (md_freq == md_tgt);
        if (md_wait == 1) begin
          md_wait = RAMP_DIV;
          if ((stopping || reversing) && md_freq > MINF) md_freq--;
          else if (stopping) enter_brake();
          else if (reversing) md_cur = !md_cur;
          else if (md_freq < md_tgt) md_freq++;
          else if (md_freq > md_tgt) md_freq--;
        end else begin
          md_wait--;
        end
        if (settled && !fire) md_mode = M_RUN;
        if (fire) begin md_tgt = c; md_tdir = cmd_dir; end
      end
      M_RUN: begin
        if (fire && (c != md_tgt || cmd_dir != md_tdir)) begin
          md_tgt = c; md_tdir = cmd_dir; md_mode = M_RAMP; md_wait = RAMP_DIV;
        end
      end
      default: begin
        md_brake--;
        if (md_brake == 0) begin
          md_mode = M_IDLE; md_freq = 0; md_tgt = 0; md_tdir = 0; md_cur = 0;
        end
      end
    endcase
    if (es && (prev_mode == M_RAMP || prev_mode == M_RUN)) enter_brake();
    if (es) md_fault = 1'b1;
  endtask

  task automatic compare_all();
    int exp_inv;
    exp_inv = (md_mode == M_BRAKE) ? 1 : ((md_mode == M_IDLE) ? 0 : int'(md_cur));
    check("m3freq", int'(m3freq), md_freq);
    check("m3start", int'(m3start), int'(md_mode != M_IDLE));
    check("m3invOrStop", int'(m3inv), exp_inv);
    check("atSpeed", int'(atspeed), int'(md_mode == M_RUN));
    check("busy", int'(busy), int'(md_mode != M_IDLE));
    check("cmdReady", int'(cmd_ready), int'((md_mode != M_BRAKE) && !md_fault));
`ifdef MOTORO3_RAMP_ESTOP_EN
    check("fault", int'(fault), int'(md_fault));
`endif
  endtask

  task automatic cycle();
    int pair;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    pair = int'({m3inv, m3freq});
    if (rec_on && pair != last_pair) begin
      seq.push_back(pair);
      last_pair = pair;
    end
  endtask

  task automatic send_cmd(input int f, input bit d);
    cmd_valid = 1'b1;
    cmd_freq  = 10'(f);
    cmd_dir   = d;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_mode(input int m, input int budget);
    for (int n = 0; n < budget && md_mode != m; n++) cycle();
  endtask

  task automatic wait_freq(input int f, input int budget);
    for (int n = 0; n < budget && md_freq != f; n++) cycle();
  endtask

  initial begin
    int exp_seq[6];
    int r;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_m3start", int'(m3start), 0);
    check("rst_m3freq", int'(m3freq), 0);
    check("rst_cmdReady", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);

    // Start and ramp to 5
    send_cmd(5, 1'b0);
    check("start_m3start", int'(m3start), 1);
    check("start_m3freq", int'(m3freq), 1);
    repeat (4) cycle();
    check("ramp_step2", int'(m3freq), 2);
    repeat (12) cycle();
    check("ramp_step5", int'(m3freq), 5);
    check("ramp_not_yet_at_speed", int'(atspeed), 0);
    cycle();
    check("run_at_speed", int'(atspeed), 1);

    // Clamp to MAX_FREQ
    do_reset();
    send_cmd(10, 1'b0);
    wait_freq(3, 100);
    send_cmd(1023, 1'b0);
    wait_mode(M_RUN, 5000);
    check("clamp_freq", int'(m3freq), 1000);
    check("clamp_at_speed", int'(atspeed), 1);
    repeat (12) cycle();
    check("clamp_hold", int'(m3freq), 1000);

    // Mid-ramp retarget reverses slope
    do_reset();
    send_cmd(10, 1'b0);
    wait_freq(6, 100);
    send_cmd(2, 1'b0);
    wait_mode(M_RUN, 200);
    check("retarget_freq", int'(m3freq), 2);
    check("retarget_at_speed", int'(atspeed), 1);

    // Direction change at constant target
    do_reset();
    send_cmd(3, 1'b0);
    wait_mode(M_RUN, 100);
    check("dir_pre_freq", int'(m3freq), 3);
    seq.delete();
    last_pair = int'({m3inv, m3freq});
    seq.push_back(last_pair);
    rec_on = 1'b1;
    send_cmd(3, 1'b1);
    wait_mode(M_RUN, 100);
    rec_on = 1'b0;
    exp_seq = '{3, 2, 1, 1024 + 1, 1024 + 2, 1024 + 3};
    check("dir_seq_len", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) check("dir_seq", seq[i], exp_seq[i]);
    check("dir_at_speed", int'(atspeed), 1);

    // Stop with brake phase
    do_reset();
    send_cmd(2, 1'b0);
    wait_mode(M_RUN, 100);
    send_cmd(0, 1'b0);
    repeat (4) cycle();
    check("stop_freq1", int'(m3freq), 1);
    repeat (4) cycle();
    check("brake_inv", int'(m3inv), 1);
    check("brake_freq", int'(m3freq), 0);
    check("brake_ready", int'(cmd_ready), 0);
    check("brake_start", int'(m3start), 1);
    repeat (7) cycle();
    check("brake_busy", int'(busy), 1);
    cycle();
    check("idle_busy", int'(busy), 0);
    check("idle_start", int'(m3start), 0);
    check("idle_ready", int'(cmd_ready), 1);
    check("idle_inv", int'(m3inv), 0);

    // Reset mid-ramp
    send_cmd(10, 1'b0);
    wait_freq(4, 100);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_freq", int'(m3freq), 0);
    check("midrst_start", int'(m3start), 0);
    check("midrst_busy", int'(busy), 0);
    send_cmd(5, 1'b0);
    check("restart_freq", int'(m3freq), 1);

`ifdef MOTORO3_RAMP_ESTOP_EN
    // Emergency stop
    do_reset();
    send_cmd(5, 1'b0);
    wait_mode(M_RUN, 100);
    e_stop = 1'b1;
    cycle();
    e_stop = 1'b0;
    check("estop_freq", int'(m3freq), 0);
    check("estop_fault", int'(fault), 1);
    check("estop_inv", int'(m3inv), 1);
    repeat (8) cycle();
    check("estop_idle", int'(busy), 0);
    check("estop_ready", int'(cmd_ready), 0);
    send_cmd(5, 1'b0);
    check("estop_locked", int'(busy), 0);
    do_reset();
    check("estop_clear", int'(fault), 0);
`endif

    // Random commands, occasional reset
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      cmd_valid = ($urandom % 6) == 0;
      cmd_dir   = $urandom % 2;
      r = $urandom % 5;
      case (r)
        0:       cmd_freq = 10'd0;
        1:       cmd_freq = 10'($urandom_range(1, 12));
        2:       cmd_freq = 10'd1023;
        3:       cmd_freq = 10'($urandom_range(1, 30));
        default: cmd_freq = 10'($urandom_range(1, 6));
      endcase
      rst = ($urandom % 400) == 0;
`ifdef MOTORO3_RAMP_ESTOP_EN
      e_stop = ($urandom % 300) == 0;
`endif
      cycle();
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
`ifdef MOTORO3_RAMP_ESTOP_EN
    e_stop = 1'b0;
`endif
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
